// File: rtl/ifm_tile_addr_gen.sv
// ifm_tile_addr_gen
// Walks one IFM tile window (channel, row, column; column innermost) and
// issues one buffer read address per pixel on a valid/ready stream.
// Pixels whose coordinates fall outside the feature map are flagged as
// padding and carry address 0. tile_done pulses once the tile has drained.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle tile start, honoured only in IDLE
//   tile_x0, tile_y0   first core column/row of the tile
//   base_addr          buffer address of pixel (c=0, y=0, x=0)
//   ifm_L, ifm_H       window width/height including padding
//   pad_edge           [0] top, [1] bottom, [2] left, [3] right
//   kernel_size        1 or 3
//   channels           input channel count
//   featuremap_W/H     feature map dimensions
//   rd_addr/pad/last   beat payload
//   rd_valid, rd_ready stream handshake
//   busy               high in RUN and DONE
//   tile_done          one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing beats, advancing on each accepted beat
// DONE  | tile drained; raises tile_done and returns to IDLE
module ifm_tile_addr_gen #(
  parameter int Ifm_Width = 9,
  parameter int ADDR_W    = 18,
  parameter int CH_W      = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [Ifm_Width-1:0] tile_x0,
  input  logic [Ifm_Width-1:0] tile_y0,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [Ifm_Width-1:0] ifm_L,
  input  logic [Ifm_Width-1:0] ifm_H,
  input  logic [3:0]           pad_edge,
  input  logic [2:0]           kernel_size,
  input  logic [CH_W-1:0]      channels,
  input  logic [Ifm_Width-1:0] featuremap_W,
  input  logic [Ifm_Width-1:0] featuremap_H,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_pad,
  output logic                 rd_last,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 busy,
  output logic                 tile_done
);

  localparam int SW = Ifm_Width + 1;
  localparam logic signed [SW-1:0] SONE = SW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [ADDR_W-1:0] sext(input logic signed [SW-1:0] v);
    return {{(ADDR_W-SW){v[SW-1]}}, v};
  endfunction

  function automatic logic is_pad(input logic signed [SW-1:0] x,
                                  input logic signed [SW-1:0] y,
                                  input logic [Ifm_Width-1:0] w,
                                  input logic [Ifm_Width-1:0] h);
    return x[SW-1] | y[SW-1] |
           (x >= $signed({1'b0, w})) | (y >= $signed({1'b0, h}));
  endfunction

  state_t                 state;
  logic [Ifm_Width-1:0]   len_q, hgt_q, fm_w_q, fm_h_q;
  logic [CH_W-1:0]        ch_q;
  logic signed [SW-1:0]   ox_q, oy_q;
  logic [ADDR_W-1:0]      plane_sz_q, row0_off_q;
  logic [CH_W-1:0]        c_q;
  logic [Ifm_Width-1:0]   r_q, k_q;
  logic signed [SW-1:0]   x_q, y_q;
  logic [ADDR_W-1:0]      plane_q, row_q;

  // Right and bottom padding fall out of the coordinate bounds check.
  logic unused_pad_bits;
  assign unused_pad_bits = ^{pad_edge[3], pad_edge[1]};

  // First-beat values, derived straight from the inputs so the first beat
  // is ready the cycle after start. The multiplies here run once per tile.
  logic                 st_pad_l, st_pad_t, st_empty, st_pad, st_last;
  logic signed [SW-1:0] st_ox, st_oy;
  logic [ADDR_W-1:0]    st_row_off, st_plane_sz, st_row, st_addr;

  always_comb begin
    st_pad_l    = pad_edge[2] & (kernel_size == 3'd3);
    st_pad_t    = pad_edge[0] & (kernel_size == 3'd3);
    st_ox       = $signed({1'b0, tile_x0}) - $signed({{Ifm_Width{1'b0}}, st_pad_l});
    st_oy       = $signed({1'b0, tile_y0}) - $signed({{Ifm_Width{1'b0}}, st_pad_t});
    // Unsigned product of the sign-extended row origin gives oy*W modulo 2^ADDR_W.
    st_row_off  = sext(st_oy) * {{(ADDR_W-Ifm_Width){1'b0}}, featuremap_W};
    st_plane_sz = {{(ADDR_W-Ifm_Width){1'b0}}, featuremap_W} *
                  {{(ADDR_W-Ifm_Width){1'b0}}, featuremap_H};
    st_row      = base_addr + st_row_off;
    st_addr     = st_row + sext(st_ox);
    st_pad      = is_pad(st_ox, st_oy, featuremap_W, featuremap_H);
    st_empty    = (ifm_L == '0) | (ifm_H == '0) | (channels == '0);
    st_last     = (ifm_L == Ifm_Width'(1)) & (ifm_H == Ifm_Width'(1)) &
                  (channels == CH_W'(1));
  end

  // Next-beat position: adds only, using registered plane and row bases.
  logic [CH_W-1:0]      nx_c;
  logic [Ifm_Width-1:0] nx_r, nx_k;
  logic signed [SW-1:0] nx_x, nx_y;
  logic [ADDR_W-1:0]    nx_plane, nx_row, nx_addr;
  logic                 nx_pad, nx_last;

  always_comb begin
    nx_c     = c_q;
    nx_r     = r_q;
    nx_k     = k_q;
    nx_x     = x_q;
    nx_y     = y_q;
    nx_plane = plane_q;
    nx_row   = row_q;
    if (k_q != len_q - 1'b1) begin
      nx_k = k_q + 1'b1;
      nx_x = x_q + SONE;
    end else if (r_q != hgt_q - 1'b1) begin
      nx_k   = '0;
      nx_x   = ox_q;
      nx_r   = r_q + 1'b1;
      nx_y   = y_q + SONE;
      nx_row = row_q + {{(ADDR_W-Ifm_Width){1'b0}}, fm_w_q};
    end else begin
      nx_k     = '0;
      nx_x     = ox_q;
      nx_r     = '0;
      nx_y     = oy_q;
      nx_c     = c_q + 1'b1;
      nx_plane = plane_q + plane_sz_q;
      nx_row   = plane_q + plane_sz_q + row0_off_q;
    end
    nx_addr = nx_row + sext(nx_x);
    nx_pad  = is_pad(nx_x, nx_y, fm_w_q, fm_h_q);
    nx_last = (nx_c == ch_q - 1'b1) & (nx_r == hgt_q - 1'b1) & (nx_k == len_q - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      hgt_q      <= '0;
      fm_w_q     <= '0;
      fm_h_q     <= '0;
      ch_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      plane_sz_q <= '0;
      row0_off_q <= '0;
      c_q        <= '0;
      r_q        <= '0;
      k_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      plane_q    <= '0;
      row_q      <= '0;
      rd_addr    <= '0;
      rd_pad     <= 1'b0;
      rd_last    <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tile_done <= 1'b0;
          if (start) begin
            len_q      <= ifm_L;
            hgt_q      <= ifm_H;
            fm_w_q     <= featuremap_W;
            fm_h_q     <= featuremap_H;
            ch_q       <= channels;
            ox_q       <= st_ox;
            oy_q       <= st_oy;
            plane_sz_q <= st_plane_sz;
            row0_off_q <= st_row_off;
            c_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            x_q        <= st_ox;
            y_q        <= st_oy;
            plane_q    <= base_addr;
            row_q      <= st_row;
            busy       <= 1'b1;
            if (st_empty) begin
              state <= DONE;
            end else begin
              state    <= RUN;
              rd_valid <= 1'b1;
              rd_pad   <= st_pad;
              rd_addr  <= st_pad ? '0 : st_addr;
              rd_last  <= st_last;
            end
          end
        end
        RUN: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              state    <= DONE;
              rd_valid <= 1'b0;
              rd_pad   <= 1'b0;
              rd_last  <= 1'b0;
              rd_addr  <= '0;
            end else begin
              c_q     <= nx_c;
              r_q     <= nx_r;
              k_q     <= nx_k;
              x_q     <= nx_x;
              y_q     <= nx_y;
              plane_q <= nx_plane;
              row_q   <= nx_row;
              rd_pad  <= nx_pad;
              rd_addr <= nx_pad ? '0 : nx_addr;
              rd_last <= nx_last;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tile_done <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rd_valid  <= 1'b0;
          busy      <= 1'b0;
          tile_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_tile_addr_gen.sv
module tb_ifm_tile_addr_gen;
  localparam int IW = 9;
  localparam int AW = 18;
  localparam int CW = 9;

  typedef logic [AW+1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] tile_x0, tile_y0, ifm_L, ifm_H, featuremap_W, featuremap_H;
  logic [AW-1:0] base_addr;
  logic [3:0]    pad_edge;
  logic [2:0]    kernel_size;
  logic [CW-1:0] channels;
  logic [AW-1:0] rd_addr;
  logic          rd_pad, rd_last, rd_valid, rd_ready, busy, tile_done;

  ifm_tile_addr_gen #(.Ifm_Width(IW), .ADDR_W(AW), .CH_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_x0(tile_x0), .tile_y0(tile_y0),
    .base_addr(base_addr), .ifm_L(ifm_L), .ifm_H(ifm_H), .pad_edge(pad_edge),
    .kernel_size(kernel_size), .channels(channels), .featuremap_W(featuremap_W),
    .featuremap_H(featuremap_H), .rd_addr(rd_addr), .rd_pad(rd_pad),
    .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a start pulse and pushes the reference beat sequence.
  task automatic start_tile(input int tx, input int ty, input int base, input int len,
                            input int hgt, input int pe, input int ks, input int ch,
                            input int fw, input int fh);
    int padl, padt, x, y;
    logic [31:0] a;
    logic p, l;
    @(negedge clk);
    tile_x0 = IW'(tx); tile_y0 = IW'(ty); base_addr = AW'(base);
    ifm_L = IW'(len); ifm_H = IW'(hgt); pad_edge = 4'(pe);
    kernel_size = 3'(ks); channels = CW'(ch);
    featuremap_W = IW'(fw); featuremap_H = IW'(fh);
    start = 1'b1;
    padl = ((pe & 4) != 0 && ks == 3) ? 1 : 0;
    padt = ((pe & 1) != 0 && ks == 3) ? 1 : 0;
    for (int c = 0; c < ch; c++)
      for (int r = 0; r < hgt; r++)
        for (int k = 0; k < len; k++) begin
          x = tx - padl + k;
          y = ty - padt + r;
          p = (x < 0 || x >= fw || y < 0 || y >= fh);
          a = p ? 32'd0 : 32'(base + c * fw * fh + y * fw + x) & 32'h3FFFF;
          l = (c == ch - 1 && r == hgt - 1 && k == len - 1);
          sb.push_back({a[AW-1:0], p, l});
        end
  endtask

  task automatic run_tile(input bit toggle, input bit inject, input int exp_beats,
                          input int exp_pads, input string tag);
    int acc = 0;
    int pads = 0;
    int done_cyc = -1;
    bit held = 1'b0;
    beat_t held_b = '0;
    beat_t cur, e;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        // Changing inputs mid-tile must not disturb the latched geometry.
        start = 1'b0;
        ifm_L = IW'(2); ifm_H = IW'(1); channels = CW'(5);
        base_addr = AW'(777); tile_x0 = IW'(3); featuremap_W = IW'(30);
      end
      if (inject && cyc == 4) start = 1'b1;
      if (inject && cyc == 5) start = 1'b0;
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      cur = {rd_addr, rd_pad, rd_last};
      if (held) chk({tag, "_stall_hold"}, 32'(cur), 32'(held_b));
      held = rd_valid && !rd_ready;
      held_b = cur;
      if (rd_valid && rd_ready) begin
        acc++;
        if (rd_pad) pads++;
        if (sb.size() == 0) chk({tag, "_extra_beat"}, 32'(acc), 32'(exp_beats));
        else begin
          e = sb.pop_front();
          chk({tag, "_beat"}, 32'(cur), 32'(e));
        end
      end
      if (tile_done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, "_tile_done_seen"}, 32'(tile_done), 32'd1);
    chk({tag, "_beats"}, 32'(acc), 32'(exp_beats));
    chk({tag, "_pads"}, 32'(pads), 32'(exp_pads));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_valid_at_done"}, 32'(rd_valid), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (!toggle) chk({tag, "_done_latency"}, 32'(done_cyc), 32'(exp_beats + 2));
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, 32'(tile_done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rd_ready = 1'b0;
    tile_x0 = '0; tile_y0 = '0; base_addr = '0; ifm_L = '0; ifm_H = '0;
    pad_edge = '0; kernel_size = 3'd3; channels = '0;
    featuremap_W = '0; featuremap_H = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tile_done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_pad", 32'(rd_pad), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    rst = 1'b0;

    // Corner tile, top/left padding, with a start pulsed mid-run.
    start_tile(0, 0, 0, 4, 4, 5, 3, 1, 8, 8);
    run_tile(1'b0, 1'b1, 16, 7, "t1_corner");

    start_tile(0, 0, 100, 4, 4, 5, 3, 2, 8, 8);
    run_tile(1'b0, 1'b0, 32, 14, "t2_two_ch");

    start_tile(4, 4, 0, 3, 3, 0, 3, 1, 8, 8);
    run_tile(1'b0, 1'b0, 9, 0, "t3_interior");

    start_tile(0, 0, 0, 4, 4, 5, 3, 1, 8, 8);
    run_tile(1'b1, 1'b0, 16, 7, "t4_stall");

    start_tile(0, 0, 0, 4, 4, 5, 3, 0, 8, 8);
    run_tile(1'b0, 1'b0, 0, 0, "t5_zero_ch");

    // Bottom-right corner: out-of-map columns/rows are pad.
    start_tile(6, 6, 0, 4, 4, 10, 3, 1, 8, 8);
    run_tile(1'b0, 1'b0, 16, 12, "t6_br_corner");

    // kernel 1 ignores pad_edge.
    start_tile(0, 0, 0, 4, 4, 5, 1, 1, 8, 8);
    run_tile(1'b0, 1'b0, 16, 0, "t7_k1");

    // Address wraps modulo 2^18.
    start_tile(4, 4, 262140, 3, 3, 0, 3, 1, 8, 8);
    run_tile(1'b0, 1'b0, 9, 0, "t8_wrap");

    start_tile(0, 0, 0, 0, 4, 5, 3, 1, 8, 8);
    run_tile(1'b0, 1'b0, 0, 0, "t9_zero_len");

    // Reset mid-tile, then a fresh tile from beat 0.
    start_tile(0, 0, 0, 4, 4, 5, 3, 1, 8, 8);
    @(negedge clk);
    start = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    sb.delete();
    start_tile(0, 0, 0, 4, 4, 5, 3, 1, 8, 8);
    run_tile(1'b0, 1'b0, 16, 7, "t10_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
